// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and constants for the round-robin arbiter
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int ARB_N     = 4;
  localparam int ARB_IDX_W = 2;

  // Expand an owner index into its one-hot grant vector.
  function automatic logic [ARB_N-1:0] idx_to_onehot(input logic [ARB_IDX_W-1:0] idx);
    logic [ARB_N-1:0] one;
    one = {{(ARB_N-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/rr_pick_4.sv
// rtl/rr_pick_4.sv - rotated-priority first-one picker with encoded winner
module rr_pick_4
  import arb_pkg::*;
(
  input  logic [ARB_N-1:0]     req,
  input  logic [ARB_IDX_W-1:0] ptr,
  output logic                 any,
  output logic [ARB_IDX_W-1:0] idx
);

  // The client after the last owner sits at position 0 of the rotated view.
  logic [ARB_IDX_W-1:0] start;
  logic [2*ARB_N-1:0]   dbl;
  logic [ARB_N-1:0]     rot;

  assign start = ptr + 2'd1;
  assign dbl   = {req, req};
  assign rot   = dbl[start +: ARB_N];

  // Lowest set bit of the rotated vector wins; add the rotation back to get the client index.
  always_comb begin
    logic [ARB_IDX_W-1:0] off;
    off = '0;
    any = |rot;
    for (int k = ARB_N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off = ARB_IDX_W'(k);
      end
    end
    idx = any ? (start + off) : '0;
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - four-client round-robin arbiter with optional hold timeout
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ARB_N-1:0]     req,
  output logic [ARB_N-1:0]     gnt,
  output logic [ARB_IDX_W-1:0] gnt_idx,
  output logic                 gnt_valid,
  output logic                 timeout
);

  // A zero MAX_HOLD still needs a one-bit counter so the logic stays well formed.
  localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_SAT   = {HOLD_W{1'b1}};
  localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);

  arb_state_t           state_q, state_d;
  logic [ARB_IDX_W-1:0] ptr_q, ptr_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [ARB_N-1:0]     gnt_q, gnt_d;
  logic [ARB_IDX_W-1:0] idx_q, idx_d;
  logic                 timeout_q, timeout_d;

  logic                 pick_any;
  logic [ARB_IDX_W-1:0] pick_idx;

  rr_pick_4 u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // State, priority pointer, hold counter and output registers; ptr=3 makes client 0 first after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd3;
      hold_q    <= '0;
      gnt_q     <= '0;
      idx_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic: grant the picked client from IDLE, then hold, release, or force release on timeout.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          gnt_d   = idx_to_onehot(pick_idx);
          idx_d   = pick_idx;
          hold_d  = HOLD_ONE;
        end
      end
      GRANT: begin
        if (!req[idx_q] || ((MAX_HOLD != 0) && (hold_q == HOLD_LIMIT))) begin
          // Releasing owner becomes last in the search order.
          state_d   = IDLE;
          gnt_d     = '0;
          idx_d     = '0;
          ptr_d     = idx_q;
          hold_d    = '0;
          timeout_d = req[idx_q];
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + HOLD_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        idx_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = |gnt_q;
  assign timeout   = timeout_q;

endmodule
